// File: rtl/instr_constructor_if.sv
// instr_constructor_if
// Bundles the two handshakes of the instruction constructor into one port.
// The field side carries one RV32I field bundle per transfer. The word side
// carries one encoded instruction, its write address and its status flags.
//
// Signals:
//   in_valid / in_ready     field bundle handshake (producer -> constructor)
//   in_opcode               instr[6:2]
//   in_rd, in_rs1, in_rs2   register indices
//   in_funct3, in_funct7    function fields
//   in_imm                  immediate (sign-extended offset or U value <<12)
//   out_valid / out_ready   encoded word handshake (constructor -> memory)
//   out_instr               encoded 32-bit instruction
//   out_addr                write address tagged onto out_instr
//   out_illegal             opcode outside the RV32I base map
//   out_err                 immediate out of range (range-check builds only)
//
// Modports:
//   master  loader/memory side (drives the fields and out_ready)
//   slave   constructor side
interface instr_constructor_if #(
   parameter int ADDR_SIZE = 32,
   parameter int WORD_SIZE = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic [4:0]           in_opcode;
   logic [4:0]           in_rd;
   logic [4:0]           in_rs1;
   logic [4:0]           in_rs2;
   logic [2:0]           in_funct3;
   logic [6:0]           in_funct7;
   logic [WORD_SIZE-1:0] in_imm;

   logic                 out_valid;
   logic                 out_ready;
   logic [WORD_SIZE-1:0] out_instr;
   logic [ADDR_SIZE-1:0] out_addr;
   logic                 out_illegal;
   logic                 out_err;

   modport master (
      output in_valid,
      input  in_ready,
      output in_opcode,
      output in_rd,
      output in_rs1,
      output in_rs2,
      output in_funct3,
      output in_funct7,
      output in_imm,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_addr,
      input  out_illegal,
      input  out_err
   );

   modport slave (
      input  in_valid,
      output in_ready,
      input  in_opcode,
      input  in_rd,
      input  in_rs1,
      input  in_rs2,
      input  in_funct3,
      input  in_funct7,
      input  in_imm,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_addr,
      output out_illegal,
      output out_err
   );
endinterface

// File: rtl/instr_constructor.sv
// instr_constructor
// Packs RV32I instruction fields plus an immediate into a 32-bit instruction
// word. This is the inverse of the field decoder. The word format is chosen
// from the 5-bit opcode (instr[6:2]). instr[1:0] is always 2'b11. Each
// accepted bundle is tagged with an auto-incrementing write address. The
// result is queued in a 2-entry FIFO so that back-pressure from instruction
// memory never reaches the loader combinationally.
//
// Parameters:
//   ADDR_SIZE  width of out_addr
//   WORD_SIZE  instruction / immediate width (32 for RV32I)
//   BYTES      address increment per accepted word
//   BASE_ADDR  address of the first word after reset or clear
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous reset, active low
//   clear  synchronous flush: empties the FIFO and reloads the address counter
//   bus    instr_constructor_if.slave (field handshake in, word handshake out)
//
// Build option:
//   IMM_RANGE_CHECK_EN  when defined, each immediate is range-checked at
//                       acceptance and the result travels with its FIFO
//                       entry as out_err. When undefined, out_err is tied
//                       low and no check logic exists. The encoding is the
//                       same in both builds.
module instr_constructor #(
   parameter int                   ADDR_SIZE = 32,
   parameter int                   WORD_SIZE = 32,
   parameter int                   BYTES     = 4,
   parameter logic [ADDR_SIZE-1:0] BASE_ADDR = '0
) (
   input logic                clk,
   input logic                rst_n,
   input logic                clear,
   instr_constructor_if.slave bus
);

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J
   } fmt_t;

   localparam logic [4:0] OP_LOAD    = 5'b00000;
   localparam logic [4:0] OP_MISCMEM = 5'b00011;
   localparam logic [4:0] OP_OPIMM   = 5'b00100;
   localparam logic [4:0] OP_AUIPC   = 5'b00101;
   localparam logic [4:0] OP_STORE   = 5'b01000;
   localparam logic [4:0] OP_OP      = 5'b01100;
   localparam logic [4:0] OP_LUI     = 5'b01101;
   localparam logic [4:0] OP_BRANCH  = 5'b11000;
   localparam logic [4:0] OP_JALR    = 5'b11001;
   localparam logic [4:0] OP_JAL     = 5'b11011;
   localparam logic [4:0] OP_SYSTEM  = 5'b11100;

   fmt_t                 fmt;
   logic                 illegal;
   logic                 is_shift;
   logic [WORD_SIZE-1:0] imm;
   logic [6:0]           tail;
   logic [WORD_SIZE-1:0] enc_word;

   logic [WORD_SIZE-1:0] mem_instr   [2];
   logic [ADDR_SIZE-1:0] mem_addr    [2];
   logic                 mem_illegal [2];

   logic                 rd_ptr;
   logic                 wr_ptr;
   logic [1:0]           count;
   logic [1:0]           count_next;
   logic [ADDR_SIZE-1:0] addr_cnt;
   logic                 in_ready_q;
   logic                 push;
   logic                 pop;

   assign imm  = bus.in_imm;
   assign tail = {bus.in_opcode, 2'b11};

   // The shift immediates (slli/srli/srai) share the OP-IMM opcode. They are
   // told apart by funct3 = 001/101, which is funct3[1:0] == 01 in both
   // cases. Their upper bits carry funct7 and only imm[4:0] is the shift
   // amount.
   assign is_shift = (bus.in_opcode == OP_OPIMM) && (bus.in_funct3[1:0] == 2'b01);

   // Map the opcode to its encoding format. An opcode that is not in the
   // base map still produces a word: it is laid out as R-type and flagged as
   // illegal, so the loader can see exactly what it asked for.
   always_comb begin
      fmt     = FMT_R;
      illegal = 1'b0;
      case (bus.in_opcode)
         OP_LUI, OP_AUIPC:                               fmt = FMT_U;
         OP_JAL:                                         fmt = FMT_J;
         OP_BRANCH:                                      fmt = FMT_B;
         OP_STORE:                                       fmt = FMT_S;
         OP_JALR, OP_LOAD, OP_OPIMM, OP_SYSTEM, OP_MISCMEM: fmt = FMT_I;
         OP_OP:                                          fmt = FMT_R;
         default:                                        illegal = 1'b1;
      endcase
   end

   // Scatter the fields into their bit positions for the selected format.
   // Immediate bits that the format has no room for are dropped without
   // warning. Range problems are reported only through the optional
   // range check.
   always_comb begin
      enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, tail};
      case (fmt)
         FMT_I: begin
            if (is_shift) begin
               enc_word = {bus.in_funct7, imm[4:0], bus.in_rs1, bus.in_funct3, bus.in_rd, tail};
            end else begin
               enc_word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, tail};
            end
         end
         FMT_S: begin
            enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], tail};
         end
         FMT_B: begin
            enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        imm[4:1], imm[11], tail};
         end
         FMT_U: begin
            enc_word = {imm[WORD_SIZE-1:12], bus.in_rd, tail};
         end
         FMT_J: begin
            enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, tail};
         end
         default: begin
         end
      endcase
   end

`ifdef IMM_RANGE_CHECK_EN
   logic enc_err;
   logic fits12;
   logic fits13;
   logic fits21;
   logic mem_err [2];

   // An N-bit signed value fits when every bit from N-1 up to the MSB is
   // equal to the sign bit. So the slice must be all ones or all zeros.
   assign fits12 = (&imm[WORD_SIZE-1:11]) | ~(|imm[WORD_SIZE-1:11]);
   assign fits13 = (&imm[WORD_SIZE-1:12]) | ~(|imm[WORD_SIZE-1:12]);
   assign fits21 = (&imm[WORD_SIZE-1:20]) | ~(|imm[WORD_SIZE-1:20]);

   // Decide whether the immediate could not be represented by its format.
   // Branch and jump offsets must also be even. U immediates must already
   // be shifted left by 12. A shift amount above 31 is an error rather
   // than a wrap.
   always_comb begin
      enc_err = 1'b0;
      case (fmt)
         FMT_I:   enc_err = is_shift ? (|imm[WORD_SIZE-1:5]) : ~fits12;
         FMT_S:   enc_err = ~fits12;
         FMT_B:   enc_err = ~fits13 | imm[0];
         FMT_J:   enc_err = ~fits21 | imm[0];
         FMT_U:   enc_err = |imm[11:0];
         default: enc_err = 1'b0;
      endcase
   end

   // The error flag is stored with its word, so it pops out together with
   // the instruction it belongs to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            mem_err[i] <= 1'b0;
         end
      end else if (push && !clear) begin
         mem_err[wr_ptr] <= enc_err;
      end
   end

   assign bus.out_err = mem_err[rd_ptr];
`else
   assign bus.out_err = 1'b0;
`endif

   assign push = bus.in_valid & in_ready_q;
   assign pop  = (count != 2'd0) & bus.out_ready;

   // Work out next cycle's occupancy. A clear empties the FIFO no matter
   // what else happens that cycle. A push and a pop in the same cycle
   // cancel out.
   always_comb begin
      count_next = count;
      if (clear) begin
         count_next = 2'd0;
      end else if (push && !pop) begin
         count_next = count + 2'd1;
      end else if (pop && !push) begin
         count_next = count - 2'd1;
      end
   end

   // FIFO pointers, occupancy, write-address counter and the registered
   // ready. in_ready comes from next cycle's occupancy and does not look at
   // out_ready. This keeps a full FIFO from taking a bundle in the same
   // cycle that a pop frees a slot, and leaves no combinational path from
   // the memory side back to the loader. The address counter wraps
   // naturally at 2^ADDR_SIZE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count      <= 2'd0;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         addr_cnt   <= BASE_ADDR;
         in_ready_q <= 1'b1;
      end else if (clear) begin
         count      <= 2'd0;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         addr_cnt   <= BASE_ADDR;
         in_ready_q <= 1'b1;
      end else begin
         count      <= count_next;
         in_ready_q <= (count_next != 2'd2);
         if (push) begin
            wr_ptr   <= ~wr_ptr;
            addr_cnt <= addr_cnt + ADDR_SIZE'(BYTES);
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
      end
   end

   // FIFO storage. Each entry is reset to zero so that the outputs read as
   // zero straight after reset. A clear only moves the pointers; stale
   // contents stay hidden behind out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            mem_instr[i]   <= '0;
            mem_addr[i]    <= '0;
            mem_illegal[i] <= 1'b0;
         end
      end else if (push && !clear) begin
         mem_instr[wr_ptr]   <= enc_word;
         mem_addr[wr_ptr]    <= addr_cnt;
         mem_illegal[wr_ptr] <= illegal;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = (count != 2'd0);
   assign bus.out_instr   = mem_instr[rd_ptr];
   assign bus.out_addr    = mem_addr[rd_ptr];
   assign bus.out_illegal = mem_illegal[rd_ptr];

endmodule

// File: tb/tb_instr_constructor.sv
// tb_instr_constructor
// Directed self-checking bench for instr_constructor. Each scenario task
// drives its own stimulus and compares outputs against hand-computed values
// one cycle-step (#1) after the rising edge. Built with IMM_RANGE_CHECK_EN,
// it expects out_err to follow the range rules. Without it, out_err must
// stay 0.
`timescale 1ns/1ps
module tb_instr_constructor;

   localparam int          ADDR_SIZE = 32;
   localparam int          WORD_SIZE = 32;
   localparam int          BYTES     = 4;
   localparam logic [31:0] BASE_ADDR = 32'h0000_1000;
`ifdef IMM_RANGE_CHECK_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   typedef struct {
      logic [4:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] instr;
      logic        ill;
      logic        err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   int          total = 0;
   int          bad = 0;
   logic [31:0] next_addr;

   instr_constructor_if #(.ADDR_SIZE(ADDR_SIZE), .WORD_SIZE(WORD_SIZE)) bus ();

   instr_constructor #(
      .ADDR_SIZE(ADDR_SIZE),
      .WORD_SIZE(WORD_SIZE),
      .BYTES(BYTES),
      .BASE_ADDR(BASE_ADDR)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .clear(clear),
      .bus(bus)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   task automatic drive_fields(input logic [4:0] op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] imm);
      bus.in_opcode = op;
      bus.in_rd     = rd;
      bus.in_rs1    = rs1;
      bus.in_rs2    = rs2;
      bus.in_funct3 = f3;
      bus.in_funct7 = f7;
      bus.in_imm    = imm;
      bus.in_valid  = 1'b1;
   endtask

   task automatic send_word(input logic [4:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] imm);
      int waited = 0;
      drive_fields(op, rd, rs1, rs2, f3, f7, imm);
      while (!bus.in_ready && waited < 50) begin
         @(posedge clk);
         #1;
         waited++;
      end
      total++;
      if (!bus.in_ready) begin
         bad++;
         $display("[TB] FAIL send_timeout: in_ready=%0b expected 1", bus.in_ready);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic pop_word();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      clear         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      drive_fields(5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      bus.in_valid  = 1'b0;
      #12;
      total += 5;
      if (bus.out_valid !== 1'b0) begin
         bad++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
      end
      if (bus.out_instr !== 32'h0) begin
         bad++; $display("[TB] FAIL reset_out_instr: got %h expected 00000000", bus.out_instr);
      end
      if (bus.out_addr !== 32'h0) begin
         bad++; $display("[TB] FAIL reset_out_addr: got %h expected 00000000", bus.out_addr);
      end
      if (bus.out_illegal !== 1'b0) begin
         bad++; $display("[TB] FAIL reset_out_illegal: got %b expected 0", bus.out_illegal);
      end
      if (bus.out_err !== 1'b0) begin
         bad++; $display("[TB] FAIL reset_out_err: got %b expected 0", bus.out_err);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
      end
      next_addr = BASE_ADDR;
   endtask

   task automatic test_encode();
      vec_t vecs[14];
      vecs[0]  = '{5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0005, 32'h0050_0093, 1'b0, 1'b0};
      vecs[1]  = '{5'b01000, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'h0000_0008, 32'h0020_A423, 1'b0, 1'b0};
      vecs[2]  = '{5'b11000, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0, 1'b0};
      vecs[3]  = '{5'b01101, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0, 1'b0};
      vecs[4]  = '{5'b11111, 5'd6, 5'd4, 5'd3, 3'd5, 7'h20, 32'h0000_0000, 32'h4032_537F, 1'b1, 1'b0};
      vecs[5]  = '{5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h8000_0093, 1'b0, 1'b1};
      vecs[6]  = '{5'b00100, 5'd3, 5'd2, 5'd0, 3'd1, 7'h00, 32'h0000_0027, 32'h0071_1193, 1'b0, 1'b1};
      vecs[7]  = '{5'b00100, 5'd3, 5'd2, 5'd0, 3'd5, 7'h20, 32'h0000_0007, 32'h4071_5193, 1'b0, 1'b0};
      vecs[8]  = '{5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h0010_00EF, 1'b0, 1'b0};
      vecs[9]  = '{5'b01100, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_0000, 32'h0020_81B3, 1'b0, 1'b0};
      vecs[10] = '{5'b01000, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFF_FFFC, 32'hFE20_AE23, 1'b0, 1'b0};
      vecs[11] = '{5'b11000, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0005, 32'h0000_0263, 1'b0, 1'b1};
      vecs[12] = '{5'b00101, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_1001, 32'h0000_1117, 1'b0, 1'b1};
      vecs[13] = '{5'b11001, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF1_00E7, 1'b0, 1'b0};
      for (int i = 0; i < 14; i++) begin
         send_word(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                   vecs[i].f3, vecs[i].f7, vecs[i].imm);
         total += 5;
         if (bus.out_valid !== 1'b1) begin
            bad++; $display("[TB] FAIL enc%0d_valid: got %b expected 1", i, bus.out_valid);
         end
         if (bus.out_instr !== vecs[i].instr) begin
            bad++; $display("[TB] FAIL enc%0d_instr: got %h expected %h", i, bus.out_instr, vecs[i].instr);
         end
         if (bus.out_addr !== next_addr) begin
            bad++; $display("[TB] FAIL enc%0d_addr: got %h expected %h", i, bus.out_addr, next_addr);
         end
         if (bus.out_illegal !== vecs[i].ill) begin
            bad++; $display("[TB] FAIL enc%0d_illegal: got %b expected %b", i, bus.out_illegal, vecs[i].ill);
         end
         if (bus.out_err !== (vecs[i].err & ERR_ON)) begin
            bad++; $display("[TB] FAIL enc%0d_err: got %b expected %b", i, bus.out_err, vecs[i].err & ERR_ON);
         end
         next_addr = next_addr + 32'd4;
         pop_word();
      end
   endtask

   task automatic test_backpressure();
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      next_addr = BASE_ADDR;
      send_word(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1);
      send_word(5'b00100, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2);
      total++;
      if (bus.in_ready !== 1'b0) begin
         bad++; $display("[TB] FAIL bp_full_ready: got %b expected 0", bus.in_ready);
      end
      drive_fields(5'b00100, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         total += 3;
         if (bus.in_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL bp_hold_ready%0d: got %b expected 0", c, bus.in_ready);
         end
         if (bus.out_instr !== 32'h0010_0093) begin
            bad++; $display("[TB] FAIL bp_hold_instr%0d: got %h expected 00100093", c, bus.out_instr);
         end
         if (bus.out_addr !== BASE_ADDR) begin
            bad++; $display("[TB] FAIL bp_hold_addr%0d: got %h expected %h", c, bus.out_addr, BASE_ADDR);
         end
      end
      pop_word();
      total += 2;
      if (bus.out_instr !== 32'h0020_0113) begin
         bad++; $display("[TB] FAIL bp_second_instr: got %h expected 00200113", bus.out_instr);
      end
      if (bus.out_addr !== BASE_ADDR + 32'd4) begin
         bad++; $display("[TB] FAIL bp_second_addr: got %h expected %h", bus.out_addr, BASE_ADDR + 32'd4);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      total++;
      if (bus.out_instr !== 32'h0020_0113) begin
         bad++; $display("[TB] FAIL bp_second_stable: got %h expected 00200113", bus.out_instr);
      end
      pop_word();
      total += 2;
      if (bus.out_instr !== 32'h0030_0193) begin
         bad++; $display("[TB] FAIL bp_third_instr: got %h expected 00300193", bus.out_instr);
      end
      if (bus.out_addr !== BASE_ADDR + 32'd8) begin
         bad++; $display("[TB] FAIL bp_third_addr: got %h expected %h", bus.out_addr, BASE_ADDR + 32'd8);
      end
      pop_word();
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++; $display("[TB] FAIL bp_drained: got %b expected 0", bus.out_valid);
      end
      next_addr = BASE_ADDR + 32'd12;
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_instr;
      bus.out_ready = 1'b1;
      drive_fields(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1);
      @(posedge clk);
      #1;
      for (int i = 2; i <= 5; i++) begin
         exp_instr = 32'h13 | ((i - 1) << 20) | ((i - 1) << 7);
         total += 4;
         if (bus.out_valid !== 1'b1) begin
            bad++; $display("[TB] FAIL b2b%0d_valid: got %b expected 1", i - 1, bus.out_valid);
         end
         if (bus.out_instr !== exp_instr) begin
            bad++; $display("[TB] FAIL b2b%0d_instr: got %h expected %h", i - 1, bus.out_instr, exp_instr);
         end
         if (bus.out_addr !== next_addr) begin
            bad++; $display("[TB] FAIL b2b%0d_addr: got %h expected %h", i - 1, bus.out_addr, next_addr);
         end
         if (bus.in_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL b2b%0d_ready: got %b expected 1", i - 1, bus.in_ready);
         end
         next_addr = next_addr + 32'd4;
         if (i <= 4) begin
            drive_fields(5'b00100, 5'(i), 5'd0, 5'd0, 3'd0, 7'h00, 32'(i));
         end else begin
            bus.in_valid = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b0;
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++; $display("[TB] FAIL b2b_drained: got %b expected 0", bus.out_valid);
      end
   endtask

   task automatic test_clear_and_reset();
      send_word(5'b00100, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5);
      send_word(5'b00100, 5'd6, 5'd0, 5'd0, 3'd0, 7'h00, 32'd6);
      drive_fields(5'b00100, 5'd9, 5'd0, 5'd0, 3'd0, 7'h00, 32'd9);
      clear = 1'b1;
      @(posedge clk);
      #1;
      total += 2;
      if (bus.out_valid !== 1'b0) begin
         bad++; $display("[TB] FAIL clear_full_valid: got %b expected 0", bus.out_valid);
      end
      if (bus.in_ready !== 1'b1) begin
         bad++; $display("[TB] FAIL clear_ready: got %b expected 1", bus.in_ready);
      end
      @(posedge clk);
      #1;
      clear = 1'b0;
      bus.in_valid = 1'b0;
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++; $display("[TB] FAIL clear_drop_valid: got %b expected 0", bus.out_valid);
      end
      send_word(5'b00100, 5'd7, 5'd0, 5'd0, 3'd0, 7'h00, 32'd7);
      total += 2;
      if (bus.out_instr !== 32'h0070_0393) begin
         bad++; $display("[TB] FAIL clear_next_instr: got %h expected 00700393", bus.out_instr);
      end
      if (bus.out_addr !== BASE_ADDR) begin
         bad++; $display("[TB] FAIL clear_next_addr: got %h expected %h", bus.out_addr, BASE_ADDR);
      end
      #3;
      rst_n = 1'b0;
      #1;
      total += 2;
      if (bus.out_valid !== 1'b0) begin
         bad++; $display("[TB] FAIL arst_valid: got %b expected 0", bus.out_valid);
      end
      if (bus.out_instr !== 32'h0) begin
         bad++; $display("[TB] FAIL arst_instr: got %h expected 00000000", bus.out_instr);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++; $display("[TB] FAIL arst_idle_valid: got %b expected 0", bus.out_valid);
      end
      send_word(5'b01101, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000);
      total += 3;
      if (bus.out_valid !== 1'b1) begin
         bad++; $display("[TB] FAIL arst_next_valid: got %b expected 1", bus.out_valid);
      end
      if (bus.out_instr !== 32'h1234_52B7) begin
         bad++; $display("[TB] FAIL arst_next_instr: got %h expected 123452B7", bus.out_instr);
      end
      if (bus.out_addr !== BASE_ADDR) begin
         bad++; $display("[TB] FAIL arst_next_addr: got %h expected %h", bus.out_addr, BASE_ADDR);
      end
      pop_word();
   endtask

   // Run the scenarios in order, then print the summary.
   initial begin
      $display("[TB] instr_constructor bench start");
      test_reset();
      test_encode();
      test_backpressure();
      test_back_to_back();
      test_clear_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
